exc_arbiter: RTL and testbench

//  MEM-stage exception arbiter: the producer side of the CP0 exception interface. Collects per-instruction

---
 rtl/exc_arbiter_pkg.sv | 37 +++
 rtl/exc_arbiter_prio_enc.sv | 36 +++
 rtl/exc_arbiter.sv | 165 ++++++++++++++++
 tb/tb_exc_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/exc_arbiter_pkg.sv
// Shared definitions for the MEM-stage exception arbiter: exception type codes, CP0 register
// addresses and field positions, and the default handler vector.
package exc_arbiter_pkg;

    localparam int EXC_TYPE_BUS = 4;
    typedef logic [EXC_TYPE_BUS-1:0] exc_type_t;

    localparam exc_type_t EXC_TYPE_NONE    = 4'd0;
    localparam exc_type_t EXC_TYPE_INT     = 4'd1;
    localparam exc_type_t EXC_TYPE_ADEL_IF = 4'd2;
    localparam exc_type_t EXC_TYPE_RI      = 4'd3;
    localparam exc_type_t EXC_TYPE_OV      = 4'd4;
    localparam exc_type_t EXC_TYPE_BP      = 4'd5;
    localparam exc_type_t EXC_TYPE_SYS     = 4'd6;
    localparam exc_type_t EXC_TYPE_ERET    = 4'd7;
    localparam exc_type_t EXC_TYPE_ADEL    = 4'd8;
    localparam exc_type_t EXC_TYPE_ADES    = 4'd9;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam int CP0_SEG_IE    = 0;
    localparam int CP0_SEG_EXL   = 1;
    localparam int CP0_SEG_IM_LO = 8;
    localparam int CP0_SEG_IM_HI = 15;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Interrupt request from effective Status/Cause: enabled, not at exception level, masked IP hit.
    function automatic logic int_request(input logic [31:0] status, input logic [31:0] cause);
        return status[CP0_SEG_IE] & ~status[CP0_SEG_EXL]
             & (|(cause[CP0_SEG_IM_HI:CP0_SEG_IM_LO] & status[CP0_SEG_IM_HI:CP0_SEG_IM_LO]));
    endfunction

endpackage

// File: rtl/exc_arbiter_prio_enc.sv
// Combinational priority encoder: interrupt plus per-instruction flags -> single exception type.
import exc_arbiter_pkg::*;

module exc_prio_enc (
    input  logic [7:0]              i_flags,
    input  logic                    i_int,
    output logic [EXC_TYPE_BUS-1:0] o_type
);

    // Fixed priority: interrupt first, then flag bits from LSB (adel_if) to MSB (ades).
    always_comb begin
        o_type = EXC_TYPE_NONE;
        if (i_int) begin
            o_type = EXC_TYPE_INT;
        end else if (i_flags[0]) begin
            o_type = EXC_TYPE_ADEL_IF;
        end else if (i_flags[1]) begin
            o_type = EXC_TYPE_RI;
        end else if (i_flags[2]) begin
            o_type = EXC_TYPE_OV;
        end else if (i_flags[3]) begin
            o_type = EXC_TYPE_BP;
        end else if (i_flags[4]) begin
            o_type = EXC_TYPE_SYS;
        end else if (i_flags[5]) begin
            o_type = EXC_TYPE_ERET;
        end else if (i_flags[6]) begin
            o_type = EXC_TYPE_ADEL;
        end else if (i_flags[7]) begin
            o_type = EXC_TYPE_ADES;
        end else begin
            o_type = EXC_TYPE_NONE;
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter feeding CP0 and the flush/redirect logic.
// Optional feature: define EXC_ARB_BYPASS_EN to forward same-cycle WB mtc0 writes to Status/Cause/EPC.
import exc_arbiter_pkg::*;

module exc_arbiter #(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid_i,
    input  logic                    mem_stall_i,
    input  logic [31:0]             mem_pc_i,
    input  logic                    mem_in_delayslot_i,
    input  logic [7:0]              mem_exc_flags_i,
    input  logic [31:0]             mem_badaddr_i,
    input  logic [31:0]             cp0_status_i,
    input  logic [31:0]             cp0_cause_i,
    input  logic [31:0]             cp0_epc_i,
    input  logic                    wb_cp0_we_i,
    input  logic [4:0]              wb_cp0_waddr_i,
    input  logic [31:0]             wb_cp0_wdata_i,
    output logic [EXC_TYPE_BUS-1:0] exception_type_o,
    output logic [31:0]             current_inst_addr_o,
    output logic                    in_delayslot_o,
    output logic [31:0]             badvaddr_o,
    output logic                    flush_o,
    output logic [31:0]             new_pc_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [0:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_pending_int;
    logic [31:0]             w_status;
    logic [31:0]             w_cause;
    logic [31:0]             w_epc;
    logic                    w_int_req;
    logic                    w_accept;
    logic [EXC_TYPE_BUS-1:0] w_type;
    logic [31:0]             w_badvaddr;
    logic                    w_unused;

`ifdef EXC_ARB_BYPASS_EN
    // Forward an in-flight WB mtc0 so mtc0 followed directly by eret/interrupt sees the new value.
    always_comb begin
        w_status = cp0_status_i;
        w_cause  = cp0_cause_i;
        w_epc    = cp0_epc_i;
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_STATUS)) begin
            w_status = wb_cp0_wdata_i;
        end else begin
            w_status = cp0_status_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_CAUSE)) begin
            w_cause = {cp0_cause_i[31:10], wb_cp0_wdata_i[9:8], cp0_cause_i[7:0]};
        end else begin
            w_cause = cp0_cause_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_EPC)) begin
            w_epc = wb_cp0_wdata_i;
        end else begin
            w_epc = cp0_epc_i;
        end
    end
`else
    assign w_status = cp0_status_i;
    assign w_cause  = cp0_cause_i;
    assign w_epc    = cp0_epc_i;
`endif

    assign w_unused  = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i, cp0_status_i, cp0_cause_i};
    assign w_int_req = int_request(w_status, w_cause);
    assign w_accept  = (r_state == ST_IDLE) & mem_valid_i & ~mem_stall_i
                     & (w_int_req | r_pending_int | (|mem_exc_flags_i));

    exc_prio_enc u_prio_enc (
        .i_flags (mem_exc_flags_i),
        .i_int   (w_int_req | r_pending_int),
        .o_type  (w_type)
    );

    // BadVAddr source follows the winning exception, not the raw flags.
    always_comb begin
        w_badvaddr = 32'h0000_0000;
        case (w_type)
            EXC_TYPE_ADEL_IF: w_badvaddr = mem_pc_i;
            EXC_TYPE_ADEL,
            EXC_TYPE_ADES:    w_badvaddr = mem_badaddr_i;
            default:          w_badvaddr = 32'h0000_0000;
        endcase
    end

    // Remember an interrupt seen on a bubble/stall so it is taken on the next real instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending_int <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_int_req && (!mem_valid_i || mem_stall_i)) begin
                r_pending_int <= 1'b1;
            end else if (w_accept || !w_int_req) begin
                r_pending_int <= 1'b0;
            end else begin
                r_pending_int <= r_pending_int;
            end
        end else begin
            r_pending_int <= r_pending_int;
        end
    end

    // IDLE/FLUSH sequencer with registered CP0 and redirect outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= ST_IDLE;
            r_cnt               <= '0;
            exception_type_o    <= EXC_TYPE_NONE;
            current_inst_addr_o <= 32'h0000_0000;
            in_delayslot_o      <= 1'b0;
            badvaddr_o          <= 32'h0000_0000;
            flush_o             <= 1'b0;
            new_pc_o            <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state             <= ST_FLUSH;
                        r_cnt               <= CNT_LOAD;
                        exception_type_o    <= w_type;
                        current_inst_addr_o <= mem_pc_i;
                        in_delayslot_o      <= mem_in_delayslot_i;
                        badvaddr_o          <= w_badvaddr;
                        flush_o             <= 1'b1;
                        new_pc_o            <= (w_type == EXC_TYPE_ERET) ? w_epc : EXC_VECTOR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // CP0 sees the exception for exactly one cycle; the redirect PC stays up.
                    exception_type_o    <= EXC_TYPE_NONE;
                    current_inst_addr_o <= 32'h0000_0000;
                    in_delayslot_o      <= 1'b0;
                    badvaddr_o          <= 32'h0000_0000;
                    if (r_cnt == '0) begin
                        r_state  <= ST_IDLE;
                        flush_o  <= 1'b0;
                        new_pc_o <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    flush_o          <= 1'b0;
                    exception_type_o <= EXC_TYPE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// Randomized scoreboard bench for exc_arbiter; the reference model works from the priority/flag rules.
import exc_arbiter_pkg::*;

module tb_exc_arbiter;

    localparam int FC = 3;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_valid_i = 1'b0, mem_stall_i = 1'b0, mem_in_delayslot_i = 1'b0, wb_cp0_we_i = 1'b0;
    logic [31:0] mem_pc_i = 32'h0, mem_badaddr_i = 32'h0, cp0_status_i = 32'h0;
    logic [31:0] cp0_cause_i = 32'h0, cp0_epc_i = 32'h0, wb_cp0_wdata_i = 32'h0;
    logic [7:0]  mem_exc_flags_i = 8'h0;
    logic [4:0]  wb_cp0_waddr_i = 5'h0;
    logic [3:0]  exception_type_o;
    logic [31:0] current_inst_addr_o, badvaddr_o, new_pc_o;
    logic        in_delayslot_o, flush_o;

    exc_arbiter #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_exc_flags_i(mem_exc_flags_i),
        .mem_badaddr_i(mem_badaddr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_wdata_i(wb_cp0_wdata_i), .exception_type_o(exception_type_o),
        .current_inst_addr_o(current_inst_addr_o), .in_delayslot_o(in_delayslot_o),
        .badvaddr_o(badvaddr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [3:0]  typ;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] badv;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          n_checks = 0, n_fail = 0;
    int          m_busy = 0;
    bit          m_pend = 1'b0, nxt_flush = 1'b0, cur_flush = 1'b0;
    logic [31:0] m_newpc = 32'h0, cur_pc = 32'h0;
    logic [3:0]  code_tbl [8] = '{EXC_TYPE_ADEL_IF, EXC_TYPE_RI, EXC_TYPE_OV, EXC_TYPE_BP,
                                  EXC_TYPE_SYS, EXC_TYPE_ERET, EXC_TYPE_ADEL, EXC_TYPE_ADES};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Reference model for the cycle whose inputs are currently driven.
    task automatic model_step();
        logic [31:0] st, ca, ep;
        logic ireq, acc;
        int idx;
        exp_t e;
        st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
`ifdef EXC_ARB_BYPASS_EN
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_wdata_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_wdata_i[9:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_wdata_i;
`endif
        ireq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
        if (m_busy == 0) begin
            acc = mem_valid_i && !mem_stall_i && (ireq || m_pend || mem_exc_flags_i != 8'h00);
            if (acc) begin
                idx = -1;
                for (int i = 0; i < 8; i++) if (mem_exc_flags_i[i] && idx < 0) idx = i;
                e.due = cyc + 1; e.addr = mem_pc_i; e.ds = mem_in_delayslot_i;
                if (ireq || m_pend) begin
                    e.typ = EXC_TYPE_INT; e.badv = 32'h0; m_newpc = VEC;
                end else begin
                    e.typ  = code_tbl[idx];
                    e.badv = (idx == 0) ? mem_pc_i : ((idx >= 6) ? mem_badaddr_i : 32'h0);
                    m_newpc = (idx == 5) ? ep : VEC;
                end
                sbq.push_back(e);
                m_busy = FC;
            end
            if (ireq && (!mem_valid_i || mem_stall_i)) m_pend = 1'b1;
            else if (acc || !ireq) m_pend = 1'b0;
        end else begin
            m_busy--;
        end
        nxt_flush = (m_busy > 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        cur_flush = nxt_flush;
        cur_pc = m_newpc;
        #1;
    endtask

    task automatic quiet();
        mem_valid_i = 1'b0; mem_stall_i = 1'b0; mem_exc_flags_i = 8'h0; mem_in_delayslot_i = 1'b0;
        cp0_status_i = 32'h0; cp0_cause_i = 32'h0; wb_cp0_we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) tick();
    endtask

    // Monitor: pops the scoreboard whenever an exception is due and checks flush/redirect each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("exc_type", 32'(exception_type_o), 32'(e.typ));
                chk("inst_addr", current_inst_addr_o, e.addr);
                chk("delayslot", 32'(in_delayslot_o), 32'(e.ds));
                chk("badvaddr", badvaddr_o, e.badv);
            end else begin
                chk("type_idle", 32'(exception_type_o), 32'(EXC_TYPE_NONE));
            end
            chk("flush", 32'(flush_o), 32'(cur_flush));
            if (cur_flush) chk("new_pc", new_pc_o, cur_pc);
        end
    end

    initial begin
        quiet();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_type", 32'(exception_type_o), 32'(EXC_TYPE_NONE));
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_newpc", new_pc_o, 32'h0);
        reset = 1'b1;
        idle(2);

        // Interrupt on a valid instruction.
        cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_1000;
        tick(); idle(5);
        // RI wins over OV, delay slot flag propagates.
        mem_valid_i = 1'b1; mem_exc_flags_i = 8'h06; mem_pc_i = 32'h8000_2004; mem_in_delayslot_i = 1'b1;
        tick(); idle(5);
        // ERET from CP0 EPC, then with a same-cycle WB write of EPC.
        mem_valid_i = 1'b1; mem_exc_flags_i = 8'h20; cp0_epc_i = 32'h8000_3000; mem_pc_i = 32'h8000_2010;
        tick(); idle(5);
        mem_valid_i = 1'b1; mem_exc_flags_i = 8'h20;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h8000_4000;
        tick(); idle(5);
        // ADES, then a second exception presented during FLUSH.
        mem_valid_i = 1'b1; mem_exc_flags_i = 8'h80; mem_badaddr_i = 32'h8000_0003; mem_pc_i = 32'h8000_2020;
        tick();
        mem_exc_flags_i = 8'h02; mem_pc_i = 32'h8000_2024;
        tick(); tick(); idle(4);
        // Interrupt during bubbles, taken on the next valid instruction.
        cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
        tick(); tick();
        cp0_cause_i = 32'h0000_0000;
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_5000;
        tick(); idle(5);
        // Stalled SYS with EXL set, accepted once unstalled.
        cp0_status_i = 32'h0000_0002;
        mem_valid_i = 1'b1; mem_stall_i = 1'b1; mem_exc_flags_i = 8'h10; mem_pc_i = 32'h8000_6000;
        tick(); tick();
        mem_stall_i = 1'b0;
        tick(); idle(5);
        // Asynchronous reset in the middle of FLUSH.
        mem_valid_i = 1'b1; mem_exc_flags_i = 8'h01; mem_pc_i = 32'h8000_7000;
        tick(); quiet(); tick();
        reset = 1'b0;
        #1;
        chk("midrst_flush", 32'(flush_o), 32'h0);
        chk("midrst_type", 32'(exception_type_o), 32'(EXC_TYPE_NONE));
        m_busy = 0; m_pend = 1'b0; sbq.delete(); cur_flush = 1'b0; nxt_flush = 1'b0;
        @(posedge clk); cyc++; #1;
        reset = 1'b1;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            mem_valid_i        = ($urandom % 4) != 0;
            mem_stall_i        = ($urandom % 5) == 0;
            mem_pc_i           = $urandom & 32'hFFFF_FFFC;
            mem_in_delayslot_i = $urandom % 2;
            mem_exc_flags_i    = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
            mem_badaddr_i      = $urandom;
            cp0_status_i       = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            cp0_cause_i        = (($urandom % 4) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            cp0_epc_i          = $urandom;
            wb_cp0_we_i        = ($urandom % 3) == 0;
            wb_cp0_waddr_i     = 5'd12 + 5'($urandom % 3);
            wb_cp0_wdata_i     = $urandom;
            tick();
        end
        idle(6);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
